// File: rtl/mc_datapath_controller_param_pkg.sv
// Shared definitions for the parametrised multi-cycle datapath/controller:
// instruction field positions, opcodes, controller state encoding and
// a helper that tells which opcodes finish with a register write-back.
package mc_pkg;

  localparam int NREG    = 4;
  localparam int INSTR_W = 16;

  // Instruction word layout: op | rd | rs | imm
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes; 0xA..0xE are unassigned and execute as NOP
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Controller states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // True for opcodes whose result is written to rd in the WB state
  function automatic logic isWbClass(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_MOV) ||
           (op == OP_DEC);
  endfunction

endpackage

// File: rtl/mc_datapath_controller_param_if.sv
// Control/program-load/debug bundle of the lab processor top. The master
// side (bench or surrounding system) drives run/step and program writes;
// the slave side (the processor) returns register and status views.
interface mc_datapath_controller_param_if
  import mc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
);

  logic                  i_run;
  logic                  i_step;
  logic                  i_prog_we;
  logic [PC_W-1:0]       i_prog_addr;
  logic [INSTR_W-1:0]    i_prog_data;

  logic [4*DATA_W-1:0]   o_regs_flat;
  logic [PC_W-1:0]       o_pc;
  logic                  o_busy;
  logic                  o_halted;
  logic                  o_instr_done;

  modport master (
    output i_run, i_step, i_prog_we, i_prog_addr, i_prog_data,
    input  o_regs_flat, o_pc, o_busy, o_halted, o_instr_done
  );

  modport slave (
    input  i_run, i_step, i_prog_we, i_prog_addr, i_prog_data,
    output o_regs_flat, o_pc, o_busy, o_halted, o_instr_done
  );

endinterface

// File: rtl/mc_datapath_controller_param_alu.sv
// Combinational ALU of the multi-cycle datapath. All arithmetic wraps
// modulo 2^DATA_W; is_zero reflects operand A for the BZ branch test.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_isZero
);

  // Result select; opcodes without a register result pass A through
  always_comb begin
    o_result = i_a;
    case (i_op)
      OP_NOP: o_result = i_a;
      OP_LDI: o_result = i_imm;
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_MOV: o_result = i_b;
      OP_DEC: o_result = i_a - DATA_W'(1);
      default: o_result = i_a;
    endcase
  end

  assign o_isZero = (i_a == '0);

endmodule

// File: rtl/mc_datapath_controller_param.sv
// Parametrised multi-cycle processor top: controller FSM, 4-entry register
// file, IR/A/B/ALUOut staging registers and a writable instruction memory.
// Instructions run FETCH -> DECODE -> EXEC [-> WB]; HALT parks for good.
module mc_datapath_controller_param
  import mc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mc_datapath_controller_param_if.slave  bus
);

  localparam int PC_W = $clog2(IMEM_DEPTH);

  logic [2:0]          r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_aluOut;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [INSTR_W-1:0]  r_imem [IMEM_DEPTH];
  logic                r_step;
  logic                r_done;

  logic [3:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs;
  logic [7:0]          w_imm8;
  logic [DATA_W-1:0]   w_imm;
  logic [PC_W-1:0]     w_target;
  logic [DATA_W-1:0]   w_aluResult;
  logic                w_isZero;
  logic                w_continue;
  logic                w_progWe;
  logic                w_taken;

  assign w_op     = r_ir[OP_MSB:OP_LSB];
  assign w_rd     = r_ir[RD_MSB:RD_LSB];
  assign w_rs     = r_ir[RS_MSB:RS_LSB];
  assign w_imm8   = r_ir[IMM_MSB:IMM_LSB];
  assign w_imm    = DATA_W'(w_imm8);
  assign w_target = r_ir[IMM_LSB +: PC_W];

  // After a retire keep going only when running freely, not single-stepping
  assign w_continue = bus.i_run && !r_step;

  // Program writes are only accepted while no instruction is in flight
  assign w_progWe = bus.i_prog_we && ((r_state == S_IDLE) || (r_state == S_HALT));

  // JMP always redirects; BZ redirects only when R[rd] was zero
  assign w_taken = (w_op == OP_JMP) || ((w_op == OP_BZ) && w_isZero);

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm    (w_imm),
    .o_result (w_aluResult),
    .o_isZero (w_isZero)
  );

  // Controller FSM with pc, IR, operand/result staging and retire strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluOut <= '0;
      r_step   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_run) begin
            r_state <= S_FETCH;
            r_step  <= 1'b0;
          end else if (bus.i_step) begin
            r_state <= S_FETCH;
            r_step  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_pc    <= r_pc + PC_W'(1);
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rd];
          r_b     <= r_regs[w_rs];
          r_state <= (w_op == OP_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_aluOut <= w_aluResult;
          if (isWbClass(w_op)) begin
            r_state <= S_WB;
          end else begin
            if (w_taken) begin
              r_pc <= w_target;
            end
            r_done <= 1'b1;
            if (w_continue) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_IDLE;
              r_step  <= 1'b0;
            end
          end
        end
        S_WB: begin
          r_done <= 1'b1;
          if (w_continue) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
            r_step  <= 1'b0;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: written only in WB, on the same edge as the retire strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_WB) begin
      r_regs[w_rd] <= r_aluOut;
    end
  end

  // Instruction memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (w_progWe) begin
      r_imem[bus.i_prog_addr] <= bus.i_prog_data;
    end
  end

  assign bus.o_regs_flat  = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign bus.o_pc         = r_pc;
  assign bus.o_busy       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                            (r_state == S_EXEC)  || (r_state == S_WB);
  assign bus.o_halted     = (r_state == S_HALT);
  assign bus.o_instr_done = r_done;

endmodule

// File: tb/tb_mc_datapath_controller_param.sv
// Directed bench for the multi-cycle processor: one 8-bit/16-word instance
// for program, step, pause and reset behaviour, and one 16-bit/4-word
// instance for pc wrap and wide arithmetic.
module tb_mc_datapath_controller_param;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cycles;
  int dones;
  int guard;
  int nPc;
  int seenPc [5];
  int expPc [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  mc_datapath_controller_param_if #(.DATA_W(8),  .PC_W(4)) busA ();
  mc_datapath_controller_param_if #(.DATA_W(16), .PC_W(2)) busB ();

  mc_datapath_controller_param #(.DATA_W(8), .IMEM_DEPTH(16)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  mc_datapath_controller_param #(.DATA_W(16), .IMEM_DEPTH(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic step);
    busA.i_run  = run;
    busA.i_step = step;
  endtask

  task automatic loadA(input logic [3:0] addr, input logic [15:0] data);
    busA.i_prog_we   = 1'b1;
    busA.i_prog_addr = addr;
    busA.i_prog_data = data;
    tick();
    busA.i_prog_we   = 1'b0;
  endtask

  task automatic loadB(input logic [1:0] addr, input logic [15:0] data);
    busB.i_prog_we   = 1'b1;
    busB.i_prog_addr = addr;
    busB.i_prog_data = data;
    tick();
    busB.i_prog_we   = 1'b0;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Cycle count includes the first FETCH cycle and the first HALT cycle
  task automatic runUntilHaltA(input int budget, output int nCycles, output int nDones);
    nCycles = 0;
    nDones  = 0;
    while (!busA.o_halted && nCycles < budget) begin
      tick();
      nCycles++;
      if (busA.o_instr_done) nDones++;
    end
    checkOutput("reachedHalt", busA.o_halted, 1);
  endtask

  task automatic countDonesA(input int nTicks, output int nDones);
    nDones = 0;
    for (int i = 0; i < nTicks; i++) begin
      tick();
      if (busA.o_instr_done) nDones++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0);
    busA.i_prog_we = 1'b0; busA.i_prog_addr = '0; busA.i_prog_data = '0;
    busB.i_run = 1'b0; busB.i_step = 1'b0;
    busB.i_prog_we = 1'b0; busB.i_prog_addr = '0; busB.i_prog_data = '0;

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("rstPc",     busA.o_pc, 0);
    checkOutput("rstBusy",   busA.o_busy, 0);
    checkOutput("rstHalted", busA.o_halted, 0);
    checkOutput("rstDone",   busA.o_instr_done, 0);
    checkOutput("rstRegs",   busA.o_regs_flat, 0);
    rst_n = 1'b1;
    tick();

    // LDI R1,5; LDI R2,3; ADD R1,R2; HALT
    loadA(4'd0, enc(OP_LDI, 2'd1, 2'd0, 8'd5));
    loadA(4'd1, enc(OP_LDI, 2'd2, 2'd0, 8'd3));
    loadA(4'd2, enc(OP_ADD, 2'd1, 2'd2, 8'd0));
    loadA(4'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    applyStimulus(1'b1, 1'b0);
    runUntilHaltA(100, cycles, dones);
    checkOutput("p1Cycles", cycles - 1, 14);
    checkOutput("p1Dones",  dones, 3);
    checkOutput("p1R1",     busA.o_regs_flat[15:8], 8'd8);
    checkOutput("p1R2",     busA.o_regs_flat[23:16], 8'd3);
    checkOutput("p1Pc",     busA.o_pc, 4);

    // HALT is sticky and ignores RUN/STEP; loading while halted stays halted
    applyStimulus(1'b1, 1'b1);
    tick(); tick(); tick();
    checkOutput("haltSticky", busA.o_halted, 1);
    checkOutput("haltPc",     busA.o_pc, 4);
    loadA(4'd9, enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    checkOutput("haltLoad",   busA.o_halted, 1);
    applyStimulus(1'b0, 1'b0);

    // Asynchronous reset mid-program, while LDI R2 is in EXEC
    pulseReset();
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("busyAfterRun", busA.o_busy, 1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("midR1", busA.o_regs_flat[15:8], 8'd5);
    checkOutput("midPc", busA.o_pc, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", busA.o_busy, 0);
    checkOutput("asyncPc",   busA.o_pc, 0);
    checkOutput("asyncRegs", busA.o_regs_flat, 0);
    checkOutput("asyncHalt", busA.o_halted, 0);
    applyStimulus(1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("relBusy", busA.o_busy, 0);
    checkOutput("relPc",   busA.o_pc, 0);

    // Countdown: LDI R0,3; DEC R0; BZ R0,4; JMP 1; HALT
    loadA(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd3));
    loadA(4'd1, enc(OP_DEC, 2'd0, 2'd0, 8'd0));
    loadA(4'd2, enc(OP_BZ,  2'd0, 2'd0, 8'd4));
    loadA(4'd3, enc(OP_JMP, 2'd0, 2'd0, 8'd1));
    loadA(4'd4, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    applyStimulus(1'b1, 1'b0);
    runUntilHaltA(200, cycles, dones);
    checkOutput("loopR0",     busA.o_regs_flat[7:0], 8'd0);
    checkOutput("loopPc",     busA.o_pc, 5);
    checkOutput("loopDones",  dones, 9);
    checkOutput("loopCycles", cycles - 1, 33);

    // DEC from zero wraps to all ones
    applyStimulus(1'b0, 1'b0);
    pulseReset();
    loadA(4'd0, enc(OP_DEC, 2'd0, 2'd0, 8'd0));
    loadA(4'd1, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    applyStimulus(1'b1, 1'b0);
    runUntilHaltA(50, cycles, dones);
    checkOutput("decWrap", busA.o_regs_flat[7:0], 8'hFF);
    checkOutput("decPc",   busA.o_pc, 2);

    // Single step: LDI R3,7; LDI R3,9
    applyStimulus(1'b0, 1'b0);
    pulseReset();
    loadA(4'd0, enc(OP_LDI, 2'd3, 2'd0, 8'd7));
    loadA(4'd1, enc(OP_LDI, 2'd3, 2'd0, 8'd9));
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("step1Busy", busA.o_busy, 1);
    countDonesA(10, dones);
    checkOutput("step1Dones", dones, 1);
    checkOutput("step1R3",    busA.o_regs_flat[31:24], 8'd7);
    checkOutput("step1Idle",  busA.o_busy, 0);
    checkOutput("step1Pc",    busA.o_pc, 1);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    countDonesA(10, dones);
    checkOutput("step2Dones", dones, 1);
    checkOutput("step2R3",    busA.o_regs_flat[31:24], 8'd9);
    checkOutput("step2Pc",    busA.o_pc, 2);

    // Pause in DECODE of ADD, with a program write attempted while busy
    pulseReset();
    loadA(4'd0, enc(OP_LDI, 2'd1, 2'd0, 8'd2));
    loadA(4'd1, enc(OP_LDI, 2'd2, 2'd0, 8'd5));
    loadA(4'd2, enc(OP_ADD, 2'd1, 2'd2, 8'd0));
    loadA(4'd3, enc(OP_LDI, 2'd1, 2'd0, 8'h55));
    loadA(4'd4, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("pauseDecPc", busA.o_pc, 3);
    applyStimulus(1'b0, 1'b0);
    busA.i_prog_we   = 1'b1;
    busA.i_prog_addr = 4'd3;
    busA.i_prog_data = enc(OP_LDI, 2'd1, 2'd0, 8'hAA);
    tick();
    busA.i_prog_we   = 1'b0;
    countDonesA(6, dones);
    checkOutput("pauseDones", dones, 1);
    checkOutput("pauseR1",    busA.o_regs_flat[15:8], 8'd7);
    checkOutput("pauseIdle",  busA.o_busy, 0);
    checkOutput("pausePc",    busA.o_pc, 3);

    // RUN and STEP together: continuous execution without idle gaps
    applyStimulus(1'b1, 1'b1);
    runUntilHaltA(50, cycles, dones);
    checkOutput("guardR1",    busA.o_regs_flat[15:8], 8'h55);
    checkOutput("runWinsCyc", cycles - 1, 6);
    applyStimulus(1'b0, 1'b0);

    // Wide instance: four NOPs, pc wraps 3 -> 0
    pulseReset();
    for (int a = 0; a < 4; a++) loadB(2'(a), enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    busB.i_run = 1'b1;
    nPc = 0;
    guard = 0;
    while (nPc < 5 && guard < 60) begin
      tick();
      guard++;
      if (busB.o_instr_done) begin
        seenPc[nPc] = int'(busB.o_pc);
        nPc++;
      end
    end
    checkOutput("wrapCount", nPc, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < nPc) checkOutput($sformatf("wrapPc%0d", i), seenPc[i], expPc[i]);
    end
    busB.i_run = 1'b0;

    // Wide arithmetic: LDI R0,0xFF; SUB R1,R0 -> 0 - 0xFF = 0xFF01
    pulseReset();
    loadB(2'd0, enc(OP_LDI, 2'd0, 2'd0, 8'hFF));
    loadB(2'd1, enc(OP_SUB, 2'd1, 2'd0, 8'd0));
    loadB(2'd2, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    busB.i_run = 1'b1;
    guard = 0;
    while (!busB.o_halted && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("wideHalt", busB.o_halted, 1);
    checkOutput("wideR0",   busB.o_regs_flat[15:0], 16'h00FF);
    checkOutput("wideR1",   busB.o_regs_flat[31:16], 16'hFF01);
    checkOutput("widePc",   busB.o_pc, 3);
    busB.i_run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_datapath_controller_param.md
# mc_datapath_controller_param

Parametrised multi-cycle datapath plus controller. Successor to the fixed 8-bit, two-register multi-cycle design. Generalises data width and program depth, adds on-the-fly program loading, single-step mode, pause at instruction boundaries, HALT and a retire strobe. It sits at the top of the lab processor and drives the register debug outputs the benches observe.

## Interface
- DATA_W, 8: datapath and register width, legal 4..32
- IMEM_DEPTH, 16: instruction memory words, power of two, 2..256; PC_W = clog2(IMEM_DEPTH)
- Register file fixed at 4 registers R0..R3; instruction word fixed at 16 bits
- clk  in  1  rising-edge clock (single clock domain)
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- RUN  in  1  level; 1 = execute continuously, 0 = pause at next instruction boundary
- STEP  in  1  in IDLE with RUN=0, a 1 sampled on an edge executes exactly one instruction
- prog_we  in  1  instruction memory write enable
- prog_addr  in  PC_W  write address
- prog_data  in  16  instruction word
- regs_flat  out  4*DATA_W  {R3,R2,R1,R0}, R0 in LSBs
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT
- instr_done  out  1  one-cycle pulse per retired instruction

## Operation
- Instruction fields: op[15:12], rd[11:10], rs[9:8], imm[7:0]. imm is zero-extended, or truncated, to DATA_W; jump targets use imm[PC_W-1:0].
- Opcodes:
  - 0 NOP
  - 1 LDI rd=imm
  - 2 ADD rd=rd+rs
  - 3 SUB rd=rd-rs
  - 4 AND
  - 5 OR
  - 6 MOV rd=rs
  - 7 JMP pc=imm
  - 8 BZ: if rd==0 then pc=imm
  - 9 DEC rd=rd-1
  - F HALT
  - A..E behave as NOP
- Arithmetic is modulo 2^DATA_W; there are no flags.
- States and transitions:
  - IDLE -> FETCH when RUN=1, or when STEP=1 (step latched).
  - FETCH: IR=imem[pc], pc=pc+1 (wraps IMEM_DEPTH-1 -> 0).
  - DECODE: A=R[rd], B=R[rs]. HALT opcode -> HALT.
  - EXEC: ALUOut computed. JMP/BZ/NOP/undefined opcodes retire here.
  - WB: R[rd]=ALUOut, retire.
  - On retire: go to FETCH if RUN=1 and the step latch is clear; otherwise go to IDLE and clear the step latch.
  - HALT is sticky until RESET. RUN and STEP are ignored in HALT.
- A taken jump overrides the FETCH increment. Not-taken BZ leaves pc unchanged.
- Program load: prog_we is honoured only in IDLE or HALT and is ignored while busy. Loading in HALT does not leave HALT.
- RUN falling mid-instruction never aborts it; the instruction completes and the block then parks in IDLE.
- RUN and STEP both 1 in IDLE: RUN wins (continuous execution).

## Timing
- Reset (asynchronous assert, synchronous-edge release): state=IDLE, pc=0, IR=0, A=B=ALUOut=0, R0..R3=0, busy=0, halted=0, instr_done=0. Instruction memory is not cleared.
- Latency from retire to the next FETCH: 0 cycles.
- Cycles per instruction:
  - WB-class (LDI/ADD/SUB/AND/OR/MOV/DEC): 4
  - JMP/BZ/NOP: 3
  - HALT: 2 (FETCH, DECODE), then HALT
- Retire: the register or pc update and instr_done=1 are written on the same edge, so results are visible when instr_done is high.
- IDLE with RUN=1 sampled on edge N: FETCH occurs in cycle N+1, and busy is high from N+1.
- prog_we write takes effect on the edge, so a word written in cycle N can be fetched from cycle N+1 onward.

## Structure
- Package mc_pkg holds: opcode localparams, state encoding (IDLE, FETCH, DECODE, EXEC, WB, HALT), field bit positions, NREG=4, INSTR_W=16.
- Sub-module mc_alu: combinational, parametrised on DATA_W, inputs op/A/B/imm, outputs result and is_zero.
- Controller FSM, register file, IR/A/B/ALUOut registers and instruction memory live in the top module.

## Test plan
- Reset: hold RESET=0 mid-program (RUN=1, in EXEC) -> all outputs 0 and state IDLE immediately, without waiting for a clock edge; after release, pc=0 and busy=0.
- LDI R1,5; LDI R2,3; ADD R1,R2; HALT with RUN=1 -> R1=8, R2=3, halted=1, pc=4, exactly 3 instr_done pulses, 14 cycles from the first FETCH to halted.
- Countdown loop, DATA_W=8: LDI R0,3; DEC R0; BZ R0,4; JMP 1; HALT -> R0=0, halted=1; DEC R0 from 0 in a separate run gives 0xFF (wrap).
- STEP: RUN=0, program LDI R3,7; LDI R3,9; pulse STEP once -> R3=7, one instr_done, state IDLE, pc=1; a second pulse gives R3=9.
- Pause and guard: drop RUN during DECODE of ADD -> ADD still writes back, then IDLE. prog_we while busy leaves memory unchanged (read back by later execution).
- PC wrap: IMEM_DEPTH=4, program of 4 NOPs, RUN=1 -> pc sequence 1,2,3,0,1; DATA_W=16 LDI R0,0xFF; SUB R0 from 0 register yields 0xFF01 arithmetic checked.
